// File: rtl/stripe_scheduler.sv
// Job sequencer for the 64-PE systolic alignment array: B fetch, A streaming, best tracking, trace framing.
// Optional STRIPE_WATCHDOG_EN adds a per-wait-phase cycle watchdog driving o_error.
module stripe_scheduler #(
  parameter int unsigned NUM_STRIPES = 16,
  parameter int unsigned SEQ_LEN     = 1024
`ifdef STRIPE_WATCHDOG_EN
  , parameter int unsigned DRAIN_LIMIT = 2048
`endif
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_go,
  output logic [9:0]   o_a_addr,
  input  logic [1:0]   i_a_data,
  output logic [3:0]   o_b_addr,
  input  logic [127:0] i_b_data,
  output logic         o_pe_start,
  output logic [1:0]   o_pe_A,
  output logic [127:0] o_pe_B,
  input  logic         i_stripe_end,
  input  logic [9:0]   i_start_position,
  input  logic [9:0]   i_end_position,
  input  logic [13:0]  i_max_score,
  input  logic [1:0]   i_trace_dir,
  output logic         o_trace_valid,
  output logic [1:0]   o_trace_dir,
  output logic [3:0]   o_stripe_idx,
  output logic [13:0]  o_best_score,
  output logic [10:0]  o_best_end,
  output logic [3:0]   o_best_stripe,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error
);

  typedef enum logic [3:0] {
    IDLE, LOAD_B, SETUP, STREAM, DRAIN, NEXT, TRACE_WAIT, TRACE, DONE
  } state_t;

  state_t       state, state_nx;
  logic [3:0]   stripe;
  logic [10:0]  acc, ptr, acc_nx, end_abs;
  logic [11:0]  acc_sum;
  logic         a_vld, squash, trace_beat;
  logic [127:0] pe_b;
  logic [13:0]  best_score;
  logic [10:0]  best_end;
  logic [3:0]   best_stripe;
  logic         trace_valid;
  logic [1:0]   trace_dir;

  assign acc_sum    = {1'b0, acc} + {2'b00, i_start_position};
  assign acc_nx     = (acc_sum >= 12'(SEQ_LEN)) ? 11'(SEQ_LEN) : acc_sum[10:0];
  assign end_abs    = {1'b0, i_end_position} + acc;
  // Stripe end kills the beat already in flight from the A memory.
  assign squash     = i_stripe_end && (state == STREAM || state == DRAIN);
  assign trace_beat = (state == TRACE_WAIT && !i_stripe_end) || state == TRACE;

`ifdef STRIPE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(DRAIN_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_wait, wd_trip, error_q;
  assign wd_wait = (state == DRAIN) || (state == TRACE_WAIT) || (state == TRACE);
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (i_go) state_nx = LOAD_B;
      LOAD_B:     state_nx = SETUP;
      SETUP:      state_nx = (acc >= 11'(SEQ_LEN)) ? DRAIN : STREAM;
      STREAM:     if (i_stripe_end) state_nx = NEXT;
                  else if (ptr == 11'(SEQ_LEN - 1)) state_nx = DRAIN;
      DRAIN:      if (i_stripe_end) state_nx = NEXT;
      NEXT:       state_nx = (stripe == 4'(NUM_STRIPES - 1)) ? TRACE_WAIT : LOAD_B;
      TRACE_WAIT: if (!i_stripe_end) state_nx = TRACE;
      TRACE:      if (i_stripe_end) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
`ifdef STRIPE_WATCHDOG_EN
    wd_trip = wd_wait && (state_nx == state) && (wd_cnt == WD_W'(DRAIN_LIMIT - 1));
    if (wd_trip) state_nx = DONE;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      stripe      <= '0;
      acc         <= '0;
      ptr         <= '0;
      a_vld       <= 1'b0;
      pe_b        <= '0;
      best_score  <= '0;
      best_end    <= '0;
      best_stripe <= '0;
      trace_valid <= 1'b0;
      trace_dir   <= '0;
    end else begin
      state       <= state_nx;
      a_vld       <= (state == STREAM) && !i_stripe_end;
      trace_valid <= trace_beat;
      trace_dir   <= trace_beat ? i_trace_dir : 2'b00;
      case (state)
        IDLE: if (i_go) begin
          stripe      <= '0;
          acc         <= '0;
          best_score  <= '0;
          best_end    <= '0;
          best_stripe <= '0;
        end
        SETUP: begin
          pe_b <= i_b_data;
          ptr  <= acc;
        end
        STREAM: ptr <= ptr + 11'd1;
        NEXT: begin
          if (i_max_score > best_score) begin
            best_score  <= i_max_score;
            best_end    <= end_abs;
            best_stripe <= stripe;
          end
          acc <= acc_nx;
          if (stripe != 4'(NUM_STRIPES - 1)) stripe <= stripe + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef STRIPE_WATCHDOG_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      wd_cnt <= (state_nx != state || !wd_wait) ? '0 : wd_cnt + 1'b1;
      if (state == IDLE && i_go) error_q <= 1'b0;
      else if (wd_trip)          error_q <= 1'b1;
    end
  end
`endif

  assign o_pe_start    = a_vld && !squash;
  assign o_pe_A        = o_pe_start ? i_a_data : 2'b00;
  assign o_a_addr      = (state == STREAM) ? ptr[9:0] : '0;
  assign o_b_addr      = (state == LOAD_B) ? stripe : '0;
  assign o_pe_B        = pe_b;
  assign o_trace_valid = trace_valid;
  assign o_trace_dir   = trace_dir;
  assign o_stripe_idx  = stripe;
  assign o_best_score  = best_score;
  assign o_best_end    = best_end;
  assign o_best_stripe = best_stripe;
  assign o_busy        = (state != IDLE) && (state != DONE);
  assign o_done        = (state == DONE);

endmodule

// File: tb/tb_stripe_scheduler.sv
// Directed bench for stripe_scheduler: memory models, a stand-in array, and hand-computed expectations.
module tb_stripe_scheduler;

  logic         clk = 1'b0;
  logic         rst_n, go, stripe_end;
  logic [9:0]   a_addr, start_pos, end_pos;
  logic [1:0]   a_data, pe_a, trace_dir;
  logic [1:0]   trace_dir_in = 2'd0;
  logic [3:0]   b_addr, stripe_idx, best_stripe;
  logic [127:0] b_data, pe_b;
  logic         pe_start, trace_valid, busy, done, error;
  logic [13:0]  max_score, best_score;
  logic [10:0]  best_end;

  int n_chk = 0, n_pass = 0;
  int beats = 0, first_addr = 0, prev_addr = 0, data_err = 0, tbeats = 0, dir_err = 0;
  logic [1:0] prev_dir = 2'd0;

  stripe_scheduler #(.NUM_STRIPES(16), .SEQ_LEN(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go),
    .o_a_addr(a_addr), .i_a_data(a_data), .o_b_addr(b_addr), .i_b_data(b_data),
    .o_pe_start(pe_start), .o_pe_A(pe_a), .o_pe_B(pe_b),
    .i_stripe_end(stripe_end), .i_start_position(start_pos), .i_end_position(end_pos),
    .i_max_score(max_score), .i_trace_dir(trace_dir_in),
    .o_trace_valid(trace_valid), .o_trace_dir(trace_dir), .o_stripe_idx(stripe_idx),
    .o_best_score(best_score), .o_best_end(best_end), .o_best_stripe(best_stripe),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] a_pat(input logic [9:0] a);
    return 2'(a ^ (a >> 3) ^ (a >> 7));
  endfunction

  function automatic logic [127:0] b_pat(input logic [3:0] s);
    return {8{12'hB5C, s}};
  endfunction

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    a_data <= a_pat(a_addr);
    b_data <= b_pat(b_addr);
  end

  always begin
    @(posedge clk);
    #1 trace_dir_in = trace_dir_in + 2'd1;
  end

  always @(negedge clk) begin
    if (pe_start) begin
      if (beats == 0) first_addr = prev_addr;
      beats++;
      if (pe_a !== a_pat(10'(prev_addr))) data_err++;
    end else if (pe_a !== 2'b00) data_err++;
    prev_addr = int'(a_addr);
    if (trace_valid) begin
      tbeats++;
      if (trace_dir !== prev_dir) dir_err++;
    end
    prev_dir = trace_dir_in;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic start_job();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    tbeats = 0; data_err = 0; dir_err = 0;
    @(negedge clk);
    check("go_busy", 128'(busy), 128'(1));
    check("go_best_clr", 128'(best_score), 128'(0));
    check("go_idx", 128'(stripe_idx), 128'(0));
  endtask

  task automatic do_stripe(input int k, input int first, input int nbeats, input int early,
                           input int sp, input int ep, input int ms, input int se_cyc);
    int n, target;
    @(posedge clk); #1;
    start_pos = 10'(sp); end_pos = 10'(ep); max_score = 14'(ms);
    stripe_end = 1'b0; beats = 0; n = 0;
    target = (early > 0) ? early : nbeats;
    if (target > 0) begin
      while (beats < target && n < 1500) begin @(posedge clk); n++; end
    end else repeat (8) @(posedge clk);
    if (early == 0) repeat (2) @(posedge clk);
    #1 stripe_end = 1'b1;
    @(negedge clk);
    check($sformatf("idx%0d", k), 128'(stripe_idx), 128'(k));
    check($sformatf("pe_b%0d", k), pe_b, b_pat(4'(k)));
    if (early > 0) check($sformatf("squash%0d", k), 128'(pe_start), 128'(0));
    repeat (se_cyc) begin @(posedge clk); #1; end
    stripe_end = 1'b0;
    @(negedge clk); #1;
    check($sformatf("beats%0d", k), 128'(beats), 128'(nbeats));
    if (nbeats > 0) check($sformatf("first%0d", k), 128'(first_addr), 128'(first));
  endtask

  task automatic finish_job(input int low, input int score, input int bend, input int bstripe);
    repeat (low) begin @(posedge clk); #1; end
    stripe_end = 1'b1;
    @(posedge clk); #1 stripe_end = 1'b0; go = 1'b1;
    @(negedge clk);
    check("done_pulse", 128'(done), 128'(1));
    check("done_busy", 128'(busy), 128'(0));
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    check("done_once", 128'(done), 128'(0));
    check("go_in_done_ignored", 128'(busy), 128'(0));
    #1;
    check("trace_beats", 128'(tbeats), 128'(low + 1));
    check("trace_dir", 128'(dir_err), 128'(0));
    check("a_data", 128'(data_err), 128'(0));
    check("best_score", 128'(best_score), 128'(score));
    check("best_end", 128'(best_end), 128'(bend));
    check("best_stripe", 128'(best_stripe), 128'(bstripe));
    check("error", 128'(error), 128'(0));
  endtask

  initial begin : main
    int ms_tab[4] = '{5, 9, 9, 3};
    int n;
    rst_n = 1'b0; go = 1'b0; stripe_end = 1'b0;
    start_pos = '0; end_pos = '0; max_score = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pe_b", pe_b, 128'(0));
    check("rst_outs", 128'({busy, done, error, pe_start, pe_a, a_addr, b_addr, trace_valid,
                            trace_dir, stripe_idx, best_score, best_end, best_stripe}), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Job 1: nominal 64-base advance, best tracking, long trace window.
    start_job();
    for (int k = 0; k < 16; k++)
      do_stripe(k, 64 * k, 1024 - 64 * k, 0, 64, 100, (k < 4) ? ms_tab[k] : 0, (k == 15) ? 2 : 1);
    finish_job(300, 9, 164, 1);

    // Job 2: early stripe ends, then reset in the middle of stripe 5's stream.
    start_job();
    do_stripe(0, 0, 9, 9, 64, 50, 3, 1);
    for (int k = 1; k < 5; k++) do_stripe(k, 64 * k, 3, 3, 64, 50, 3, 1);
    @(posedge clk); #1 beats = 0; n = 0;
    while (beats < 5 && n < 100) begin @(posedge clk); n++; end
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("mid_first", 128'(first_addr), 128'(320));
    check("mid_rst_pe_b", pe_b, 128'(0));
    check("mid_rst_outs", 128'({busy, done, error, pe_start, pe_a, a_addr, b_addr, trace_valid,
                                trace_dir, stripe_idx, best_score, best_end, best_stripe}), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Job 3: restart from zero, saturation of the start accumulator, tie on best score.
    start_job();
    do_stripe(0, 0, 2, 2, 1023, 0, 0, 1);
    do_stripe(1, 1023, 1, 0, 5, 0, 0, 1);
    do_stripe(2, 0, 0, 0, 0, 10, 7, 1);
    do_stripe(3, 0, 0, 0, 0, 0, 0, 1);
    do_stripe(4, 0, 0, 0, 0, 200, 7, 1);
    for (int k = 5; k < 16; k++) do_stripe(k, 0, 0, 0, 0, 0, 0, (k == 15) ? 2 : 1);
    finish_job(4, 7, 1034, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stripe_scheduler.md
Name: stripe_scheduler

Overview:
- Sequences the 64-PE systolic alignment array (PE_array_64) over a full job of NUM_STRIPES stripes.
- Per stripe: fetches 64 query bases (B) as one 128-bit word and streams reference bases (A) from the carried start position.
- Drains the array until stripe end, accumulates the start position and tracks the global best score.
- After the last stripe, frames the trace-back beat stream.

Parameters:
NUM_STRIPES, 16, stripes per job (B length = 64*NUM_STRIPES)
SEQ_LEN, 1024, reference (A) length in bases
DRAIN_LIMIT, 2048, watchdog cycle limit per wait phase (only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_go  in  1  start-job pulse; ignored while o_busy=1
o_a_addr  out  10  A memory read address; synchronous read, 1-cycle latency
i_a_data  in  2  A memory read data
o_b_addr  out  4  B memory stripe address; synchronous read, 1-cycle latency
i_b_data  in  128  B memory data, 64 bases, base n at [2n+:2]
o_pe_start  out  1  to array i_start
o_pe_A  out  2  to array i_A
o_pe_B  out  128  to array i_B; registered, held for the whole stripe
i_stripe_end  in  1  from array o_stripe_end
i_start_position  in  10  from array, next-stripe start offset, relative
i_end_position  in  10  from array, relative end offset
i_max_score  in  14  from array, stripe max score
i_trace_dir  in  2  from array trace direction
o_trace_valid  out  1  trace beat valid
o_trace_dir  out  2  registered i_trace_dir
o_stripe_idx  out  4  current stripe
o_best_score  out  14  best stripe max so far
o_best_end  out  11  absolute end position of best stripe
o_best_stripe  out  4  stripe index of best
o_busy  out  1  job active
o_done  out  1  one-cycle pulse at job end
o_error  out  1  sticky watchdog flag

Behaviour:
- Reset (sync, i_rst_n=0 at a clock edge) is honoured in any state, including mid-job:
  - State goes to IDLE.
  - All outputs go to 0; o_pe_B is cleared.
  - The start accumulator acc (11-bit) is cleared; the in-flight A read is discarded.
- IDLE: on i_go, go to LOAD_B with stripe=0, acc=0, best cleared, o_busy=1.
- LOAD_B: drive o_b_addr=stripe for 1 cycle, then go to SETUP.
- SETUP:
  - Register o_pe_B<=i_b_data; o_pe_start=0 for exactly one cycle (the array's stripe boundary gap).
  - Load address pointer ptr=acc.
  - If acc>=SEQ_LEN, go to DRAIN; else go to STREAM.
- STREAM:
  - Each cycle issue o_a_addr=ptr, then ptr++.
  - A registered valid flag aligns o_pe_start with i_a_data one cycle later.
  - o_pe_A = i_a_data when o_pe_start=1, else 2'b00.
  - After address SEQ_LEN-1 is issued, go to DRAIN; its beat still emerges one cycle later.
- DRAIN: o_pe_start=0, o_pe_A=0; wait for i_stripe_end.
- Stripe end:
  - i_stripe_end=1 sampled in STREAM or DRAIN causes a move to NEXT on the next cycle.
  - The in-flight A beat is squashed: o_pe_start=0 from that cycle.
- NEXT (one cycle) performs all of the following in the same cycle:
  - end_abs = {1'b0,i_end_position} + acc.
  - If i_max_score > o_best_score (strict; ties keep the earlier stripe), update best_score, best_end=end_abs and best_stripe.
  - acc <= acc + i_start_position, saturating at SEQ_LEN.
  - If stripe==NUM_STRIPES-1, go to TRACE_WAIT; else stripe++ and go to LOAD_B.
- TRACE_WAIT: wait for i_stripe_end=0, then go to TRACE.
- TRACE:
  - o_trace_valid=1 every cycle; o_trace_dir = i_trace_dir registered.
  - The cycle in which i_stripe_end=1 is the final beat; then go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, go to IDLE. Best outputs are held until the next i_go.
- i_go during o_busy=1 is ignored.
- i_go in the same cycle as the DONE→IDLE transition is ignored.

Optional Feature:
STRIPE_WATCHDOG_EN
- Defined:
  - A cycle counter runs in DRAIN, TRACE_WAIT and TRACE, cleared on every state entry.
  - On reaching DRAIN_LIMIT: set o_error=1 (sticky until reset or next i_go), pulse o_done, go to IDLE.
- Undefined: no counter; o_error tied 0; waits are unbounded.

Test Plan:
- Nominal job, model array returns i_start_position=64 each stripe -> 16 stripes; stripe k streams A from address 64k to 1023; o_done after TRACE; 1 zero-start gap cycle per stripe.
- Early stripe end: assert i_stripe_end on the 10th STREAM beat -> o_pe_start=0 on the same cycle; no further A beats; next stripe starts at acc+i_start_position.
- Saturation: i_start_position=1023 on stripe 0 -> acc=1023; stripe 1 streams one beat (addr 1023); stripe 2 has acc=1024, skips STREAM, and o_pe_start stays 0.
- Best tracking: stripe maxima 5, 9, 9, 3 with i_end_position=100 and acc=64·k -> o_best_score=9, o_best_stripe=1, o_best_end=164.
- Trace framing: i_stripe_end high 2 cycles after the last stripe, then low 300 cycles, then high -> exactly 301 o_trace_valid beats with matching dir; o_done pulse.
- Reset mid-STREAM at stripe 5 -> next cycle all outputs 0 and IDLE; a new i_go restarts at stripe 0 with acc=0. With STRIPE_WATCHDOG_EN, never asserting i_stripe_end -> o_error=1 after 2048 DRAIN cycles.
